mb8_mult_arbiter: RTL

//  Shares one pipelined radix-8 Booth multiplier (mb8_top, fixed LAT-cycle latency, no valid/stall) among NREQ requesters.

---
 rtl/mb8_pkg.sv | 24 ++
 rtl/mb8_rr_pick.sv | 43 ++++
 rtl/mb8_mult_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mb8_pkg.sv
// Shared definitions for the radix-8 Booth multiplier arbiter.
//   DefWidth / DefLat : default operand width and multiplier latency
//   MaxIdw            : widest requester ID carried in a tag (up to 16 requesters)
//   arb_state_e       : arbiter FSM states
//   tag_t             : one tag-pipe slot, valid bit plus owning requester ID
package mb8_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefLat   = 3;
  localparam int unsigned MaxIdw   = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StDrain  = 2'd2,
    StHalted = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              v;
    logic [MaxIdw-1:0] id;
  } tag_t;

endpackage

// File: rtl/mb8_rr_pick.sv
// Combinational round-robin pick.
//   valid_i : request vector
//   ptr_i   : highest-priority index this cycle
//   grant_o : one-hot grant (zero when nothing is valid)
//   idx_o   : index of the granted requester
//   any_o   : some requester is valid
module mb8_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  localparam int unsigned SW = IDW + 1;

  logic [SW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = SW'(ptr_i) + SW'(k);
      if (cand >= SW'(NREQ)) begin
        cand = cand - SW'(NREQ);
      end
      if (valid_i[cand[IDW-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand[IDW-1:0];
      end
    end
    if (any_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/mb8_mult_arbiter.sv
// Shares one fixed-latency pipelined multiplier among NREQ requesters.
//   CLK, RST            : clock, synchronous active-high reset
//   req_valid/x/y       : per-requester operands, packed i*WIDTH +: WIDTH
//   req_ready           : one-hot grant, handshake = valid & ready at posedge
//   hold / halted       : stop issuing and drain; halted once the pipe is empty
//   mul_x/mul_y, mul_p  : registered operands to, and product from, the multiplier
//   rsp_valid/id/p      : granted result with the owning requester ID
// Optional build macro MB8_ARB_PERF_EN adds perf_grants (per-requester saturating
// grant counts, 16 bits each) and perf_busy (saturating count of granting cycles).
module mb8_mult_arbiter
  import mb8_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LAT   = DefLat,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  hold,
  output logic                  halted,
  output logic [WIDTH-1:0]      mul_x,
  output logic [WIDTH-1:0]      mul_y,
  input  logic [2*WIDTH-1:0]    mul_p,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_p
`ifdef MB8_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0]    perf_grants,
  output logic [15:0]           perf_busy
`endif
);

  localparam int unsigned SW = IDW + 1;

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [SW-1:0]  ptr_inc;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           grant_en, handshake, tags_busy;
  logic [WIDTH-1:0] mul_x_q, mul_y_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  tag_t           tag_q [LAT];
  logic           unused_tag_id;

  mb8_rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .valid_i(req_valid),
    .ptr_i  (ptr_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Grants are also masked during reset so no requester sees a phantom handshake.
  assign grant_en  = ((state_q == StIdle) || (state_q == StIssue)) && !hold && !RST;
  assign req_ready = grant_en ? pick_grant : '0;
  assign handshake = grant_en && pick_any;

  always_comb begin
    ptr_inc = SW'(pick_idx) + SW'(1);
    ptr_d   = (ptr_inc == SW'(NREQ)) ? '0 : ptr_inc[IDW-1:0];
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      tags_busy = tags_busy | tag_q[i].v;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (hold)            state_d = StDrain;
        else if (|req_valid) state_d = StIssue;
      end
      StIssue: begin
        if (hold)            state_d = StDrain;
        else if (!(|req_valid)) state_d = StIdle;
      end
      StDrain: begin
        if (!hold)           state_d = StIdle;
        else if (!tags_busy) state_d = StHalted;
      end
      StHalted: begin
        if (!hold)           state_d = StIdle;
      end
      default:               state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (handshake) begin
        ptr_q <= ptr_d;
      end
      // Idle slots carry zero operands and an invalid tag: bubbles are never reported.
      mul_x_q     <= handshake ? req_x[pick_idx*WIDTH +: WIDTH] : '0;
      mul_y_q     <= handshake ? req_y[pick_idx*WIDTH +: WIDTH] : '0;
      tag_q[0].v  <= handshake;
      tag_q[0].id <= handshake ? MaxIdw'(pick_idx) : '0;
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      // Registered so the response lines up with the product LAT cycles after mul_x.
      rsp_valid_q <= tag_q[LAT-1].v;
      rsp_id_q    <= tag_q[LAT-1].id[IDW-1:0];
    end
  end

  assign unused_tag_id = ^tag_q[LAT-1].id;

  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = mul_p;
  assign halted    = (state_q == StHalted);

`ifdef MB8_ARB_PERF_EN
  logic [15:0] perf_grants_q [NREQ];
  logic [15:0] perf_busy_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_busy_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        perf_grants_q[i] <= '0;
      end
    end else if (handshake) begin
      if (perf_busy_q != '1) perf_busy_q <= perf_busy_q + 16'd1;
      if (perf_grants_q[pick_idx] != '1) begin
        perf_grants_q[pick_idx] <= perf_grants_q[pick_idx] + 16'd1;
      end
    end
  end

  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < NREQ; i++) begin
      perf_grants[i*16 +: 16] = perf_grants_q[i];
    end
  end

  assign perf_busy = perf_busy_q;
`endif

endmodule
